// File: rtl/ofs_plat_prim_pipe_pkg.sv
// Shared types for the ready/enable pipeline: pipe mode selection and the
// per-stage occupancy state.
package ofs_plat_prim_pipe_pkg;

   typedef enum logic [1:0] {
      PIPE_BYPASS,
      PIPE_SKID,
      PIPE_SIMPLE
   } t_pipe_mode;

   // FULL is reachable only in skid stages (main + skid register both hold a beat).
   typedef enum logic [1:0] {
      STAGE_EMPTY,
      STAGE_ONE,
      STAGE_FULL
   } t_stage_state;

endpackage

// File: rtl/ofs_plat_prim_ready_enable_pipe_if.sv
// Ready/enable stream bundle: enable + payload + last flow master->slave,
// ready flows slave->master.
interface ofs_plat_prim_ready_enable_pipe_if #(
   parameter int N_DATA_BITS = 64
);
   logic                   enable;
   logic [N_DATA_BITS-1:0] data;
   logic                   last;
   logic                   ready;

   modport master (output enable, output data, output last, input ready);
   modport slave  (input enable, input data, input last, output ready);
endinterface

// File: rtl/ofs_plat_prim_ready_enable_stage.sv
// One registered ready/enable stage. SKID keeps a second register so the
// registered ready still sustains one beat per cycle; SIMPLE holds a single beat.
module ofs_plat_prim_ready_enable_stage
   import ofs_plat_prim_pipe_pkg::*;
#(
   parameter t_pipe_mode MODE   = PIPE_SKID,
   parameter int         N_BITS = 65
)(
   input  logic              clk,
   input  logic              reset,

   input  logic              src_enable,
   input  logic [N_BITS-1:0] src_data,
   output logic              src_ready,

   output logic              dst_enable,
   output logic [N_BITS-1:0] dst_data,
   input  logic              dst_ready
);
   localparam bit IS_SKID = (MODE == PIPE_SKID);

   t_stage_state      state_q, state_d;
   logic              ready_q, ready_d;
   logic [N_BITS-1:0] main_q, skid_q;
   logic              in_xfer, out_xfer;
   logic              load_main_src, load_main_skid, load_skid;

   assign src_ready  = ready_q;
   assign dst_enable = (state_q != STAGE_EMPTY);
   assign dst_data   = main_q;
   assign in_xfer    = src_enable && ready_q;
   assign out_xfer   = dst_enable && dst_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      state_d        = state_q;
      load_main_src  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state_q)
         STAGE_EMPTY: begin
            if (in_xfer) begin
               state_d       = STAGE_ONE;
               load_main_src = 1'b1;
            end
         end
         STAGE_ONE: begin
            // A SIMPLE stage never sees in_xfer here: its ready is low while it holds a beat.
            if (in_xfer && out_xfer) begin
               load_main_src = 1'b1;
            end else if (in_xfer) begin
               state_d   = STAGE_FULL;
               load_skid = 1'b1;
            end else if (out_xfer) begin
               state_d = STAGE_EMPTY;
            end
         end
         STAGE_FULL: begin
            if (out_xfer) begin
               state_d        = STAGE_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = STAGE_EMPTY;
      endcase
      ready_d = IS_SKID ? (state_d != STAGE_FULL) : (state_d == STAGE_EMPTY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= STAGE_EMPTY;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
      end
   end

   // NOTE: payload registers carry no reset; the state register alone decides whether they mean anything.
   always_ff @(posedge clk) begin
      if (load_main_src) begin
         main_q <= src_data;
      end else if (load_main_skid) begin
         main_q <= skid_q;
      end
      if (load_skid) begin
         skid_q <= src_data;
      end
   end

endmodule

// File: rtl/ofs_plat_prim_ready_enable_pipe.sv
// N-stage ready/enable register slice with occupancy and complete-packet counts
// derived from the two end-point handshakes.
module ofs_plat_prim_ready_enable_pipe
   import ofs_plat_prim_pipe_pkg::*;
#(
   parameter int         N_DATA_BITS = 64,
   parameter int         NUM_STAGES  = 2,
   parameter t_pipe_mode MODE        = PIPE_SKID,
   parameter int         CNT_BITS    = $clog2(2 * NUM_STAGES + 1)
)(
   input  logic                 clk,
   input  logic                 reset,
   ofs_plat_prim_ready_enable_pipe_if.slave  src,
   ofs_plat_prim_ready_enable_pipe_if.master dst,
   output logic [CNT_BITS-1:0]  occupancy,
   output logic [CNT_BITS-1:0]  pkt_count
);
   localparam int W = N_DATA_BITS + 1;

   generate
      if (MODE == PIPE_BYPASS) begin : g_bypass
         assign dst.enable = src.enable;
         assign dst.data   = src.data;
         assign dst.last   = src.last;
         assign src.ready  = dst.ready;
         assign occupancy  = '0;
         assign pkt_count  = '0;
      end else begin : g_pipe
         logic         chain_enable [NUM_STAGES+1];
         logic         chain_ready  [NUM_STAGES+1];
         logic [W-1:0] chain_data   [NUM_STAGES+1];
         logic         in_acc, out_acc;

         // The chain carries {last, data} so the marker can never slip relative to its beat.
         assign chain_enable[0]          = src.enable;
         assign chain_data[0]            = {src.last, src.data};
         assign src.ready                = chain_ready[0];
         assign dst.enable               = chain_enable[NUM_STAGES];
         assign {dst.last, dst.data}     = chain_data[NUM_STAGES];
         assign chain_ready[NUM_STAGES]  = dst.ready;

         for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
            ofs_plat_prim_ready_enable_stage #(
               .MODE   (MODE),
               .N_BITS (W)
            ) stage (
               .clk        (clk),
               .reset      (reset),
               .src_enable (chain_enable[i]),
               .src_data   (chain_data[i]),
               .src_ready  (chain_ready[i]),
               .dst_enable (chain_enable[i+1]),
               .dst_data   (chain_data[i+1]),
               .dst_ready  (chain_ready[i+1])
            );
         end

         assign in_acc  = src.enable && src.ready;
         assign out_acc = dst.enable && dst.ready;

         always_ff @(posedge clk) begin
            if (reset) begin
               occupancy <= '0;
               pkt_count <= '0;
            end else begin
               occupancy <= occupancy + CNT_BITS'(in_acc) - CNT_BITS'(out_acc);
               pkt_count <= pkt_count + CNT_BITS'(in_acc && src.last)
                                      - CNT_BITS'(out_acc && dst.last);
            end
         end
      end
   endgenerate

endmodule
